valve_sequencer: RTL and testbench
==================================

Name: valve_sequencer

Overview:
- Downstream stage of the irrigation controller FSM; consumes its per-zone valve requests (R1, R2) and error code (E).
- Drives four physical valve outputs.
- Enforces staggered opening (one valve per STAGGER_CYC), a minimum on-time, and a maximum on-time watchdog.
- Latches faults until operator acknowledge.

Parameters:
STAGGER_CYC, 4, minimum cycles between two successive valve openings (>=1)
MIN_ON_CYC, 8, minimum cycles a valve stays open once opened (>=1)
MAX_ON_CYC, 256, continuous open cycles that trigger timeout fault (> MIN_ON_CYC)
CW, 10, width of per-valve on-timer and stagger counter; must hold MAX_ON_CYC

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_r1  in  2  zone-1 valve requests from controller FSM, 1 = water (Agua)
req_r2  in  2  zone-2 valve requests, 1 = water
err_in  in  2  controller error code: 2'b00 Error, 2'b01 no-error, 2'b1x illegal
fault_ack  in  1  single-cycle operator acknowledge
valve  out  4  valve drive {r2[1],r2[0],r1[1],r1[0]}, 1 = open, registered
busy  out  1  any valve open or request pending
fault  out  1  latched fault
fault_code  out  2  00 none, 01 upstream, 10 timeout, 11 illegal err_in
open_events  out  16  saturating count of valve openings (see Optional Feature)

Behaviour:
- Reset (async): valve=0, busy=0, fault=0, fault_code=00, open_events=0, all timers 0, state IDLE.
- Top FSM states: IDLE, RUN, FAULT.
  - IDLE -> RUN when any request bit is 1.
  - RUN -> IDLE when valve==0 and no request.
  - Any state -> FAULT on a fault condition.
  - FAULT -> IDLE on fault_ack while err_in==2'b01.
- Request vector: req = {req_r2, req_r1}. Pending = req & ~valve.
- Opening:
  - At a rising edge, if state != FAULT, pending != 0 and stagger counter == 0, the lowest-index pending valve is set to 1.
  - Latency: request present before edge k with stagger free -> valve high after edge k.
  - The same edge loads the stagger counter with STAGGER_CYC-1; it decrements to 0 and holds there.
  - Only one valve opens per edge.
- On-timer (per valve):
  - Cleared at the open edge; increments each cycle while open; saturates.
- Closing:
  - A valve with req bit 0 closes at the first edge where it has been high >= MIN_ON_CYC cycles.
  - Re-asserting the request during the min-hold keeps the valve open; the timer is not restarted.
- Timeout:
  - A valve high for MAX_ON_CYC consecutive cycles closes at that edge.
  - Enter FAULT, fault_code=10.
- Upstream error:
  - err_in==00 sampled -> all valves 0 next edge (min-hold overridden).
  - Enter FAULT, fault_code=01.
- Illegal err_in (10/11): same action, fault_code=11.
- In FAULT: valve forced 0, requests ignored, busy=0, fault=1.
  - fault_ack with err_in still 00 or illegal is ignored.
  - On exit: fault_code=00, stagger counter=0, timers cleared.
- Fault priority when several coincide in one edge: illegal > upstream > timeout. The first fault code latched is held until ack.
- Simultaneous open and fault on the same edge: fault wins, valve stays 0.
- Reset mid-operation: immediate valve=0 regardless of min-hold.

Optional Feature:
- Macro: VALVE_SEQ_STATS_EN.
- Defined: open_events increments by 1 at each valve open edge, saturates at 16'hFFFF, cleared only by reset.
- Undefined: open_events tied to 16'h0000, no counter logic synthesized.

Decomposition:
- Package valve_seq_pkg holds:
  - enum seq_state_t {IDLE, RUN, FAULT}
  - enum fault_code_t {FC_NONE=2'b00, FC_UPSTREAM=2'b01, FC_TIMEOUT=2'b10, FC_ILLEGAL=2'b11}
  - constants ERR_ERROR=2'b00, ERR_NE=2'b01, AGUA=1'b1
- Sub-module valve_timer, instantiated 4x:
  - Inputs: open pulse and valve state.
  - Outputs: min_met and timeout flags.
  - Holds the saturating CW-bit on-timer.

Test Plan:
- All four requests set at edge 1, err_in=01 -> valves open at edges 1,5,9,13 in order bit0..bit3; busy=1 from edge 1.
- req_r1=01 for 2 cycles then 00 -> valve[0] high exactly 8 cycles, then 0; busy drops the following edge.
- req_r1=01 held 300 cycles -> valve[0] falls after 256 high cycles; fault=1, fault_code=10. fault_ack with err_in=01 -> IDLE; valve reopens next edge.
- Two valves open, err_in=00 for 1 cycle -> valve=0 next edge, fault_code=01. fault_ack while err_in=00 ignored; ack with err_in=01 clears.
- err_in=11 with valve open -> valve=0, fault_code=11. Async reset asserted mid-cycle while valve open -> valve=0 immediately, fault=0.
- VALVE_SEQ_STATS_EN defined, 5 open events -> open_events=5. Undefined -> stays 0.

Source files
------------

// File: rtl/valve_seq_pkg.sv
// ---------------------------------------------------------------------------
// valve_seq_pkg
// Shared types and constants for the valve sequencer slice.
//   seq_state_t  : top-level sequencer state (IDLE, RUN, FAULT)
//   fault_code_t : latched fault cause as seen on fault_code
//   ERR_*        : controller error-code encodings on err_in
//   AGUA         : request bit value meaning "water this valve"
//   lowest_one() : isolates the lowest set bit of a 4-bit vector
// ---------------------------------------------------------------------------
package valve_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } seq_state_t;

   typedef enum logic [1:0] {
      FC_NONE     = 2'b00,
      FC_UPSTREAM = 2'b01,
      FC_TIMEOUT  = 2'b10,
      FC_ILLEGAL  = 2'b11
   } fault_code_t;

   localparam logic [1:0] ERR_ERROR = 2'b00;
   localparam logic [1:0] ERR_NE    = 2'b01;
   localparam logic       AGUA      = 1'b1;

   // Two's-complement trick: vec & -vec keeps only the lowest set bit.
   function automatic logic [3:0] lowest_one(input logic [3:0] vec);
      return vec & (~vec + 4'd1);
   endfunction

endpackage

// File: rtl/valve_sequencer_if.sv
// ---------------------------------------------------------------------------
// valve_sequencer_if
// Bundles the controller-facing and valve-facing signals of the sequencer.
//   req_r1, req_r2 : per-zone valve requests (controller -> sequencer)
//   err_in         : controller error code   (controller -> sequencer)
//   fault_ack      : operator acknowledge    (controller -> sequencer)
//   valve          : {r2[1],r2[0],r1[1],r1[0]} drive, 1 = open
//   busy, fault    : status flags
//   fault_code     : latched fault cause
//   open_events    : saturating open counter (zero when stats are disabled)
// Modports: master = controller / bench side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface valve_sequencer_if;
   import valve_seq_pkg::*;

   logic [1:0]  req_r1;
   logic [1:0]  req_r2;
   logic [1:0]  err_in;
   logic        fault_ack;
   logic [3:0]  valve;
   logic        busy;
   logic        fault;
   fault_code_t fault_code;
   logic [15:0] open_events;

   modport master (
      output req_r1, req_r2, err_in, fault_ack,
      input  valve, busy, fault, fault_code, open_events
   );

   modport slave (
      input  req_r1, req_r2, err_in, fault_ack,
      output valve, busy, fault, fault_code, open_events
   );

endinterface

// File: rtl/valve_timer.sv
// ---------------------------------------------------------------------------
// valve_timer
// Per-valve saturating on-timer. The count is cleared on the open pulse and
// whenever the valve is closed, and advances once per cycle while open, so
// (count + 1) equals the number of cycles the valve has been high.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   open_pulse    : valve opens at this edge
//   valve_on      : current registered valve state
//   min_met       : valve has been high at least MIN_ON_CYC cycles
//   timeout       : valve has been high MAX_ON_CYC cycles
// ---------------------------------------------------------------------------
module valve_timer #(
   parameter int MIN_ON_CYC = 8,
   parameter int MAX_ON_CYC = 256,
   parameter int CW         = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic open_pulse,
   input  logic valve_on,
   output logic min_met,
   output logic timeout
);

   logic [CW-1:0] on_cnt;

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         on_cnt <= '0;
      end else if (open_pulse || !valve_on) begin
         on_cnt <= '0;
      end else if (on_cnt != {CW{1'b1}}) begin
         on_cnt <= on_cnt + CW'(1);
      end
   end

   assign min_met = valve_on && (on_cnt >= CW'(MIN_ON_CYC - 1));
   assign timeout = valve_on && (on_cnt >= CW'(MAX_ON_CYC - 1));

endmodule

// File: rtl/valve_sequencer.sv
// ---------------------------------------------------------------------------
// valve_sequencer
// Turns per-zone valve requests into staggered valve openings with a
// minimum on-time, a maximum on-time watchdog and latched faults that are
// held until the operator acknowledges with a clean error code.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : valve_sequencer_if.slave (requests, err_in, fault_ack in;
//            valve, busy, fault, fault_code, open_events out)
// Build option: define VALVE_SEQ_STATS_EN to count valve openings on
// open_events; otherwise open_events is constant zero.
// ---------------------------------------------------------------------------
module valve_sequencer
   import valve_seq_pkg::*;
#(
   parameter int STAGGER_CYC = 4,
   parameter int MIN_ON_CYC  = 8,
   parameter int MAX_ON_CYC  = 256,
   parameter int CW          = 10
) (
   input logic              clk,
   input logic              reset,
   valve_sequencer_if.slave bus
);

   seq_state_t    state, state_next;
   fault_code_t   code_q, fault_sel;
   logic [3:0]    valve_q, valve_next;
   logic [3:0]    req, pending, open_vec;
   logic [3:0]    min_met, timeout;
   logic [CW-1:0] stagger;
   logic          busy_q, busy_next;
   logic          illegal, upstream, fault_now;

   // Bits equal to AGUA ask for water on that valve.
   assign req     = {bus.req_r2, bus.req_r1} & {4{AGUA}};
   assign pending = req & ~valve_q;

   for (genvar i = 0; i < 4; i++) begin : g_timer
      valve_timer #(
         .MIN_ON_CYC (MIN_ON_CYC),
         .MAX_ON_CYC (MAX_ON_CYC),
         .CW         (CW)
      ) u_timer (
         .clk        (clk),
         .reset      (reset),
         .open_pulse (open_vec[i]),
         .valve_on   (valve_q[i]),
         .min_met    (min_met[i]),
         .timeout    (timeout[i])
      );
   end

   // Fault detection and priority: illegal > upstream > timeout.
   assign illegal   = bus.err_in[1];
   assign upstream  = (bus.err_in == ERR_ERROR);
   assign fault_now = illegal || upstream || (|timeout);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves a signal unassigned (which would infer a latch).
      fault_sel  = FC_NONE;
      state_next = state;
      valve_next = valve_q;
      open_vec   = '0;

      if (illegal)        fault_sel = FC_ILLEGAL;
      else if (upstream)  fault_sel = FC_UPSTREAM;
      else if (|timeout)  fault_sel = FC_TIMEOUT;

      unique case (state)
         IDLE:    if (|req) state_next = RUN;
         RUN:     if (valve_q == '0 && req == '0) state_next = IDLE;
         FAULT:   if (bus.fault_ack && bus.err_in == ERR_NE) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (fault_now) state_next = FAULT;

      if (state == FAULT || fault_now) begin
         // A fault overrides min-hold and any opening on the same edge.
         valve_next = '0;
      end else begin
         // Close released valves that have served their minimum on-time.
         valve_next = valve_q & ~(~req & min_met);
         if (stagger == '0) open_vec = lowest_one(pending);
         valve_next = valve_next | open_vec;
      end

      busy_next = (state_next != FAULT) && ((|valve_q) || (|pending));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valve_q <= '0;
         busy_q  <= 1'b0;
         stagger <= '0;
         code_q  <= FC_NONE;
      end else begin
         valve_q <= valve_next;
         busy_q  <= busy_next;

         // Held at zero through FAULT so the first request after ack
         // opens without waiting out an old stagger window.
         if (state == FAULT)     stagger <= '0;
         else if (|open_vec)     stagger <= CW'(STAGGER_CYC - 1);
         else if (stagger != '0) stagger <= stagger - CW'(1);

         // First fault code is held; later faults in FAULT do not overwrite.
         if (state != FAULT && fault_now)                code_q <= fault_sel;
         else if (state == FAULT && state_next == IDLE)  code_q <= FC_NONE;
      end
   end

`ifdef VALVE_SEQ_STATS_EN
   logic [15:0] events_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                 events_q <= '0;
      else if (|open_vec && events_q != 16'hFFFF) events_q <= events_q + 16'd1;
   end

   assign bus.open_events = events_q;
`else
   assign bus.open_events = 16'h0000;
`endif

   assign bus.valve      = valve_q;
   assign bus.busy       = busy_q;
   assign bus.fault      = (state == FAULT);
   assign bus.fault_code = code_q;

endmodule

// File: tb/tb_valve_sequencer.sv
// ---------------------------------------------------------------------------
// tb_valve_sequencer
// Directed self-checking bench for valve_sequencer with default parameters
// (STAGGER_CYC=4, MIN_ON_CYC=8, MAX_ON_CYC=256). Inputs change and outputs
// are sampled on the falling clock edge. Expected open_events follows the
// VALVE_SEQ_STATS_EN build option.
// ---------------------------------------------------------------------------
module tb_valve_sequencer;
   import valve_seq_pkg::*;

   logic clk;
   logic reset;
   int   n_compared;
   int   n_mismatched;
   int   n_opens;
   int   hi;

   valve_sequencer_if bus ();

   valve_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed,
                        input logic [15:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] exp_events();
`ifdef VALVE_SEQ_STATS_EN
      return 16'(n_opens);
`else
      return 16'h0000;
`endif
   endfunction

   initial begin
      n_compared    = 0;
      n_mismatched  = 0;
      n_opens       = 0;
      reset         = 1'b1;
      bus.req_r1    = 2'b00;
      bus.req_r2    = 2'b00;
      bus.err_in    = ERR_NE;
      bus.fault_ack = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_valve", 16'(bus.valve), 16'h0);
      check("rst_busy", 16'(bus.busy), 16'h0);
      check("rst_fault", 16'(bus.fault), 16'h0);
      check("rst_code", 16'(bus.fault_code), 16'h0);
      check("rst_events", bus.open_events, 16'h0);
      reset = 1'b0;
      tick();
      check("idle_valve", 16'(bus.valve), 16'h0);

      // Staggered opening: all four requested -> edges 1,5,9,13
      bus.req_r1 = 2'b11;
      bus.req_r2 = 2'b11;
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("stagger_e%0d", k), 16'(bus.valve),
               (k < 5) ? 16'h1 : (k < 9) ? 16'h3 : (k < 13) ? 16'h7 : 16'hF);
         if (k == 1) check("stagger_busy_e1", 16'(bus.busy), 16'h1);
      end
      n_opens += 4;
      check("stagger_events", bus.open_events, exp_events());

      // Release all: v0,v1 already served min; v2 closes at 17, v3 at 21
      bus.req_r1 = 2'b00;
      bus.req_r2 = 2'b00;
      tick();
      check("release_e14", 16'(bus.valve), 16'hC);
      tick(); tick();
      check("release_e16", 16'(bus.valve), 16'hC);
      tick();
      check("release_e17", 16'(bus.valve), 16'h8);
      tick(); tick(); tick();
      check("release_e20", 16'(bus.valve), 16'h8);
      tick();
      check("release_e21", 16'(bus.valve), 16'h0);
      check("release_busy_e21", 16'(bus.busy), 16'h1);
      tick();
      check("release_busy_e22", 16'(bus.busy), 16'h0);
      check("release_fault", 16'(bus.fault), 16'h0);

      // Minimum on-time: request for 2 cycles -> exactly 8 high cycles
      bus.req_r1 = 2'b01;
      tick();
      check("minon_open", 16'(bus.valve), 16'h1);
      n_opens++;
      tick();
      bus.req_r1 = 2'b00;
      hi = 2;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.valve[0]) hi++;
         else break;
      end
      check("minon_high_cycles", 16'(hi), 16'd8);
      check("minon_busy_at_close", 16'(bus.busy), 16'h1);
      tick();
      check("minon_busy_after", 16'(bus.busy), 16'h0);

      // Max on-time watchdog: held request -> 256 high cycles then timeout
      bus.req_r1 = 2'b01;
      tick();
      check("tmo_open", 16'(bus.valve), 16'h1);
      n_opens++;
      hi = 1;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (bus.valve[0]) hi++;
         else break;
      end
      check("tmo_high_cycles", 16'(hi), 16'd256);
      check("tmo_fault", 16'(bus.fault), 16'h1);
      check("tmo_code", 16'(bus.fault_code), 16'(FC_TIMEOUT));
      check("tmo_busy", 16'(bus.busy), 16'h0);
      tick(); tick();
      check("tmo_req_ignored", 16'(bus.valve), 16'h0);
      bus.fault_ack = 1'b1;
      tick();
      bus.fault_ack = 1'b0;
      check("tmo_ack_fault", 16'(bus.fault), 16'h0);
      check("tmo_ack_code", 16'(bus.fault_code), 16'(FC_NONE));
      tick();
      check("tmo_reopen", 16'(bus.valve), 16'h1);
      n_opens++;

      // Upstream error with two valves open
      bus.req_r1 = 2'b11;
      tick(); tick(); tick();
      check("up_stagger_wait", 16'(bus.valve), 16'h1);
      tick();
      check("up_two_open", 16'(bus.valve), 16'h3);
      n_opens++;
      bus.err_in = ERR_ERROR;
      tick();
      check("up_valve", 16'(bus.valve), 16'h0);
      check("up_fault", 16'(bus.fault), 16'h1);
      check("up_code", 16'(bus.fault_code), 16'(FC_UPSTREAM));
      bus.fault_ack = 1'b1;
      tick();
      check("up_ack_ignored", 16'(bus.fault), 16'h1);
      check("up_ack_ignored_code", 16'(bus.fault_code), 16'(FC_UPSTREAM));
      bus.err_in = ERR_NE;
      tick();
      bus.fault_ack = 1'b0;
      check("up_cleared", 16'(bus.fault), 16'h0);
      check("up_cleared_code", 16'(bus.fault_code), 16'(FC_NONE));
      tick();
      check("up_reopen", 16'(bus.valve), 16'h1);
      n_opens++;

      // Illegal error code; first code held while err_in changes
      bus.err_in = 2'b11;
      tick();
      check("ill_valve", 16'(bus.valve), 16'h0);
      check("ill_code", 16'(bus.fault_code), 16'(FC_ILLEGAL));
      bus.err_in = ERR_ERROR;
      tick();
      check("ill_code_held", 16'(bus.fault_code), 16'(FC_ILLEGAL));
      bus.err_in = 2'b10;
      bus.fault_ack = 1'b1;
      tick();
      check("ill_ack_ignored", 16'(bus.fault), 16'h1);
      bus.err_in = ERR_NE;
      tick();
      bus.fault_ack = 1'b0;
      check("ill_cleared", 16'(bus.fault), 16'h0);
      tick();
      check("ill_reopen", 16'(bus.valve), 16'h1);
      n_opens++;
      check("events_total", bus.open_events, exp_events());

      // Asynchronous reset in mid-cycle with a valve open
      #2 reset = 1'b1;
      #1;
      check("async_rst_valve", 16'(bus.valve), 16'h0);
      check("async_rst_fault", 16'(bus.fault), 16'h0);
      check("async_rst_events", bus.open_events, 16'h0);
      @(negedge clk);
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
